// File: rtl/instr_stream_pkg.sv
// rtl/instr_stream_pkg.sv - shared constants, FSM encoding and byte helper for the instruction byte streamer
//
// Purpose : framing marker bytes, escape mask, FSM state encoding and a word-to-byte
//           selector shared by instr_byte_streamer and byte_escaper.
// Ports   : none (package).

package instr_stream_pkg;

   localparam logic [7:0] START_BYTE_C = 8'hFE;
   localparam logic [7:0] END_BYTE_C   = 8'hFF;
   localparam logic [7:0] ESC_BYTE_C   = 8'hFD;
   localparam logic [7:0] ESC_MASK     = 8'h20;

   localparam int BYTES_PER_WORD = 4;
   localparam int IDX_W          = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_FETCH,
      ST_ESC,
      ST_END
   } state_t;

   // Byte idx of a word, MSB first: idx 0 -> [31:24], idx 3 -> [7:0].
   function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [IDX_W-1:0] idx);
      case (idx)
         2'd0:    get_byte = word[31:24];
         2'd1:    get_byte = word[23:16];
         2'd2:    get_byte = word[15:8];
         default: get_byte = word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/byte_escaper.sv
// rtl/byte_escaper.sv - combinational marker detection and escape transform for one data byte
//
// Purpose : flags a data byte that collides with a framing marker and supplies its
//           escaped replacement (byte ^ ESC_MASK).
// Ports   : data      in  8  raw data byte
//           needs_esc out 1  data equals START, END or ESC marker
//           escaped   out 8  data ^ ESC_MASK

module byte_escaper
   import instr_stream_pkg::*;
#(
   parameter logic [7:0] START_BYTE = START_BYTE_C,
   parameter logic [7:0] END_BYTE   = END_BYTE_C,
   parameter logic [7:0] ESC_BYTE   = ESC_BYTE_C
)(
   input  logic [7:0] data,
   output logic       needs_esc,
   output logic [7:0] escaped
);

   assign needs_esc = (data == START_BYTE) || (data == END_BYTE) || (data == ESC_BYTE);
   assign escaped   = data ^ ESC_MASK;

endmodule

// File: rtl/instr_byte_streamer.sv
// rtl/instr_byte_streamer.sv - frames 32-bit instruction words into a START/data/END byte stream
//
// Purpose : accepts instruction words over valid/ready and emits START_BYTE, the word
//           bytes MSB first, then END_BYTE, one byte per accepted cycle. Consecutive
//           words chain without a valid gap. A frame is force-closed after MAX_WORDS.
// Option  : define INSTR_STREAM_ESC_EN to escape data bytes that alias a marker
//           (ESC_BYTE followed by byte ^ 8'h20); otherwise data bytes are sent raw.
// Ports   : clk           in   1      clock
//           reset         in   1      asynchronous active-low reset
//           word_i        in   32     instruction word
//           word_last_i   in   1      last word of program
//           word_valid_i  in   1      word_i/word_last_i valid
//           word_ready_o  out  1      word accepted on valid && ready
//           byte_o        out  8      serial byte, 0 when not valid
//           byte_valid_o  out  1      byte_o valid
//           byte_ready_i  in   1      sink accepts byte_o
//           busy_o        out  1      frame in progress
//           word_cnt_o    out  CNT_W  words in current/last frame
//           overflow_o    out  1      frame closed by MAX_WORDS (sticky until next frame)
//           frame_done_o  out  1      pulse when END_BYTE accepted

module instr_byte_streamer
   import instr_stream_pkg::*;
#(
   parameter int         MAX_WORDS  = 64,
   parameter logic [7:0] START_BYTE = START_BYTE_C,
   parameter logic [7:0] END_BYTE   = END_BYTE_C,
   parameter logic [7:0] ESC_BYTE   = ESC_BYTE_C,
   localparam int        CNT_W      = $clog2(MAX_WORDS + 1)
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      word_i,
   input  logic             word_last_i,
   input  logic             word_valid_i,
   output logic             word_ready_o,
   output logic [7:0]       byte_o,
   output logic             byte_valid_o,
   input  logic             byte_ready_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] word_cnt_o,
   output logic             overflow_o,
   output logic             frame_done_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

   state_t           state;
   logic [31:0]      word_q;
   logic             last_q;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] word_cnt;
   logic             overflow_q;
   logic             done_q;
   logic             run;       // holds word_ready_o low until the first edge after reset
   logic [7:0]       byte_q;
   logic             valid_q;

   logic             byte_acc;
   logic             word_acc;
   logic             can_chain;
   logic [CNT_W-1:0] cnt_inc;
   logic [31:0]      src_word;
   logic [IDX_W-1:0] src_idx;
   logic [7:0]       src_byte;
   logic             needs_esc;
   logic [7:0]       esc_byte;
   state_t           ld_state;
   logic [7:0]       ld_byte;

   assign byte_acc  = valid_q && byte_ready_i;
   // Next word may be taken on the same edge as the final byte of the current word.
   assign can_chain = (state == ST_DATA) && (idx == LAST_IDX) && byte_ready_i &&
                      !last_q && (word_cnt < MAX_CNT);
   assign word_ready_o = run && ((state == ST_IDLE) || (state == ST_FETCH) || can_chain);
   assign word_acc  = word_valid_i && word_ready_o;
   assign cnt_inc   = (word_cnt == MAX_CNT) ? word_cnt : word_cnt + 1'b1;

   // Source of the next data byte to load: the next index of the held word, byte 0 of a
   // newly accepted word, or (in ESC) the held byte itself so its escaped form is available.
   always_comb begin
      src_word = word_q;
      src_idx  = '0;
      case (state)
         ST_DATA: begin
            if (idx == LAST_IDX) src_word = word_i;
            else                 src_idx  = idx + 1'b1;
         end
         ST_ESC:   src_idx  = idx;
         ST_FETCH: src_word = word_i;
         default: ;
      endcase
      src_byte = get_byte(src_word, src_idx);
   end

`ifdef INSTR_STREAM_ESC_EN
   byte_escaper #(
      .START_BYTE (START_BYTE),
      .END_BYTE   (END_BYTE),
      .ESC_BYTE   (ESC_BYTE)
   ) u_escaper (
      .data       (src_byte),
      .needs_esc  (needs_esc),
      .escaped    (esc_byte)
   );
`else
   assign needs_esc = 1'b0;
   assign esc_byte  = src_byte;
`endif

   // An aliasing byte is preceded by ESC_BYTE; ESC then emits the transformed byte.
   assign ld_state = needs_esc ? ST_ESC : ST_DATA;
   assign ld_byte  = needs_esc ? ESC_BYTE : src_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         word_q     <= '0;
         last_q     <= 1'b0;
         idx        <= '0;
         word_cnt   <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         run        <= 1'b0;
         byte_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         run    <= 1'b1;
         done_q <= 1'b0;
         case (state)
            ST_IDLE: if (word_acc) begin
               word_q     <= word_i;
               last_q     <= word_last_i;
               word_cnt   <= '0;
               overflow_q <= 1'b0;
               byte_q     <= START_BYTE;
               valid_q    <= 1'b1;
               state      <= ST_START;
            end
            ST_START: if (byte_acc) begin
               word_cnt <= cnt_inc;
               idx      <= src_idx;
               byte_q   <= ld_byte;
               state    <= ld_state;
            end
            ST_DATA: if (byte_acc) begin
               if (idx != LAST_IDX) begin
                  idx    <= src_idx;
                  byte_q <= ld_byte;
                  state  <= ld_state;
               end else if (word_acc) begin
                  word_q   <= word_i;
                  last_q   <= word_last_i;
                  word_cnt <= cnt_inc;
                  idx      <= src_idx;
                  byte_q   <= ld_byte;
                  state    <= ld_state;
               end else if (last_q || (word_cnt == MAX_CNT)) begin
                  overflow_q <= !last_q;
                  byte_q     <= END_BYTE;
                  state      <= ST_END;
               end else begin
                  valid_q <= 1'b0;
                  byte_q  <= '0;
                  state   <= ST_FETCH;
               end
            end
            ST_ESC: if (byte_acc) begin
               byte_q <= esc_byte;
               state  <= ST_DATA;
            end
            ST_FETCH: if (word_acc) begin
               word_q   <= word_i;
               last_q   <= word_last_i;
               word_cnt <= cnt_inc;
               idx      <= src_idx;
               byte_q   <= ld_byte;
               valid_q  <= 1'b1;
               state    <= ld_state;
            end
            ST_END: if (byte_acc) begin
               valid_q <= 1'b0;
               byte_q  <= '0;
               done_q  <= 1'b1;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign byte_o       = byte_q;
   assign byte_valid_o = valid_q;
   assign busy_o       = (state != ST_IDLE);
   assign word_cnt_o   = word_cnt;
   assign overflow_o   = overflow_q;
   assign frame_done_o = done_q;

endmodule

// File: tb/tb_instr_byte_streamer.sv
// tb/tb_instr_byte_streamer.sv - directed self-checking bench for instr_byte_streamer

module tb_instr_byte_streamer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] word_i;
   logic        word_last_i;
   logic        word_valid_i;
   logic        word_ready_o;
   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic        byte_ready_i;
   logic        busy_o;
   logic [6:0]  word_cnt_o;
   logic        overflow_o;
   logic        frame_done_o;

   instr_byte_streamer dut (
      .clk          (clk),
      .reset        (reset),
      .word_i       (word_i),
      .word_last_i  (word_last_i),
      .word_valid_i (word_valid_i),
      .word_ready_o (word_ready_o),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .busy_o       (busy_o),
      .word_cnt_o   (word_cnt_o),
      .overflow_o   (overflow_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   int          done_cnt = 0;
   int          gap_cnt  = 0;
   logic        ovf_at_done = 1'b0;
   logic [6:0]  cnt_at_done = '0;
   logic [7:0]  got[$];
   logic [7:0]  exp_q[$];
   int          d0, gap0, nff;
   logic        seen;

   // Sink-side monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         if (byte_valid_o && byte_ready_i) got.push_back(byte_o);
         if (busy_o && !byte_valid_o) gap_cnt <= gap_cnt + 1;
         if (frame_done_o) begin
            done_cnt    <= done_cnt + 1;
            ovf_at_done <= overflow_o;
            cnt_at_done <= word_cnt_o;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_stream(input string tag);
      chk({tag, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? {24'b0, got[i]} : 32'hFFFF_FFFF, {24'b0, exp_q[i]});
   endtask

   // Present one word from posedge+1; returns at posedge+1 after it is accepted.
   task automatic send(input logic [31:0] w, input logic l);
      logic acc;
      acc = 1'b0;
      word_i = w;
      word_last_i = l;
      word_valid_i = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (word_ready_o) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) chk("accept_tmo", {31'b0, acc}, 1);
      @(posedge clk);
      #1;
      word_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int n);
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (done_cnt >= n) break;
      end
      if (done_cnt < n) chk("done_tmo", done_cnt, n);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_byte34();
      seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         #1;
         if (byte_valid_o && byte_o == 8'h34) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("byte34_tmo", {31'b0, seen}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      word_i = '0;
      word_last_i = 1'b0;
      word_valid_i = 1'b0;
      byte_ready_i = 1'b1;
      #2;
      chk("rst_valid", byte_valid_o, 0);
      chk("rst_byte", byte_o, 0);
      chk("rst_ready", word_ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_cnt", word_cnt_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_done", frame_done_o, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("rel_ready_before_edge", word_ready_o, 0);
      @(posedge clk);
      #1;
      chk("rel_ready_after_edge", word_ready_o, 1);

      // 1: single-word frame
      got.delete(); gap0 = gap_cnt; d0 = done_cnt;
      send(32'h12345678, 1'b1);
      chk("t1_start_byte", byte_o, 8'hFE);
      chk("t1_start_valid", byte_valid_o, 1);
      chk("t1_start_rdy", word_ready_o, 0);
      chk("t1_busy", busy_o, 1);
      wait_done(d0 + 1);
      repeat (3) @(posedge clk);
      #1;
      exp_q = '{8'hFE, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
      chk_stream("t1");
      chk("t1_done_pulses", done_cnt - d0, 1);
      chk("t1_cnt", word_cnt_o, 1);
      chk("t1_gap", gap_cnt - gap0, 0);
      chk("t1_ovf", overflow_o, 0);
      chk("t1_idle", busy_o, 0);

      // 2: two chained words, no gap
      got.delete(); gap0 = gap_cnt; d0 = done_cnt;
      send(32'hAABBCCDD, 1'b0);
      send(32'h01020304, 1'b1);
      wait_done(d0 + 1);
      exp_q = '{8'hFE, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
      chk_stream("t2");
      chk("t2_gap", gap_cnt - gap0, 0);
      chk("t2_cnt", word_cnt_o, 2);

      // 3: sink back-pressure while byte 34 is presented
      got.delete(); d0 = done_cnt;
      fork
         send(32'h12345678, 1'b1);
         begin
            wait_byte34();
            byte_ready_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(posedge clk);
               #1;
               chk("t3_hold_byte", byte_o, 8'h34);
               chk("t3_hold_valid", byte_valid_o, 1);
            end
            byte_ready_i = 1'b1;
         end
      join
      wait_done(d0 + 1);
      exp_q = '{8'hFE, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
      chk_stream("t3");

      // 4: 65 words without last -> forced close after 64, 65th opens a new frame
      got.delete(); d0 = done_cnt;
      for (int i = 0; i < 65; i++) send(32'h1000_0000 + i, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      chk("t4_done", done_cnt - d0, 1);
      chk("t4_ovf_at_end", ovf_at_done, 1);
      chk("t4_cnt_at_end", cnt_at_done, 64);
      chk("t4_len", got.size(), 263);
      if (got.size() >= 263) begin
         chk("t4_first", got[0], 8'hFE);
         chk("t4_w0b0", got[4], 8'h00);
         chk("t4_w1b3", got[5], 8'h10);
         chk("t4_w63b0", got[256], 8'h3F);
         chk("t4_end", got[257], 8'hFF);
         chk("t4_restart", got[258], 8'hFE);
         chk("t4_w64b3", got[259], 8'h10);
         chk("t4_w64b0", got[262], 8'h40);
      end
      chk("t4_ovf_cleared", overflow_o, 0);
      chk("t4_cnt_new", word_cnt_o, 1);
      chk("t4_busy_fetch", busy_o, 1);
      chk("t4_fetch_valid", byte_valid_o, 0);
      chk("t4_fetch_ready", word_ready_o, 1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 5: asynchronous reset in the middle of DATA
      got.delete(); d0 = done_cnt;
      fork
         send(32'h12345678, 1'b1);
         wait_byte34();
      join
      #2;
      reset = 1'b0;
      #1;
      chk("t5_valid", byte_valid_o, 0);
      chk("t5_byte", byte_o, 0);
      chk("t5_busy", busy_o, 0);
      chk("t5_ready", word_ready_o, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      nff = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] == 8'hFF) nff++;
      chk("t5_no_end", nff, 0);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_idle", busy_o, 0);
      chk("t5_cnt", word_cnt_o, 0);

      // 6: data bytes that alias the markers
      got.delete(); gap0 = gap_cnt; d0 = done_cnt;
      send(32'hFEFF00FD, 1'b1);
      wait_done(d0 + 1);
`ifdef INSTR_STREAM_ESC_EN
      exp_q = '{8'hFE, 8'hFD, 8'hDE, 8'hFD, 8'hDF, 8'h00, 8'hFD, 8'hDD, 8'hFF};
`else
      exp_q = '{8'hFE, 8'hFE, 8'hFF, 8'h00, 8'hFD, 8'hFF};
`endif
      chk_stream("t6");
      chk("t6_gap", gap_cnt - gap0, 0);
      chk("t6_cnt", word_cnt_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
